// File: rtl/sync_arith_pkg.sv
// Shared types and constants for the sync_arith arbiter: FSM states,
// arithmetic-unit op codes and status bit positions.
package sync_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] OP_KONW  = 2'b00;
  localparam logic [1:0] OP_PORO  = 2'b01;
  localparam logic [1:0] OP_UST   = 2'b10;
  localparam logic [1:0] OP_PRZES = 2'b11;

  localparam int ERR       = 3;
  localparam int ODD_ZEROS = 2;
  localparam int ZEROS     = 1;
  localparam int OVF       = 0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the
// requester that was not granted last (i_last = index granted last).
module rr_arbiter2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  // one-hot grant decode
  always_comb begin
    o_grant = 2'b00;
    case ({i_valid1, i_valid0})
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sync_arith_arbiter.sv
// Shares one registered arithmetic unit between two requesters through an
// IDLE/ISSUE/CAPTURE/RESP sequence. Define SYNC_ARITH_ERR_CNT_EN to get the
// saturating error-response counter on o_err_count.
module sync_arith_arbiter #(
  parameter int BITS = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req0_valid,
  input  logic                   i_req1_valid,
  input  logic signed [BITS-1:0] i_req0_arg_A,
  input  logic signed [BITS-1:0] i_req0_arg_B,
  input  logic signed [BITS-1:0] i_req1_arg_A,
  input  logic signed [BITS-1:0] i_req1_arg_B,
  input  logic [1:0]             i_req0_op,
  input  logic [1:0]             i_req1_op,
  output logic                   o_req0_ready,
  output logic                   o_req1_ready,
  output logic signed [BITS-1:0] o_alu_arg_A,
  output logic signed [BITS-1:0] o_alu_arg_B,
  output logic [1:0]             o_alu_op,
  input  logic [BITS-1:0]        i_alu_result,
  input  logic [3:0]             i_alu_status,
  output logic                   o_rsp0_valid,
  output logic                   o_rsp1_valid,
  input  logic                   i_rsp0_ready,
  input  logic                   i_rsp1_ready,
  output logic [BITS-1:0]        o_rsp_result,
  output logic [3:0]             o_rsp_status,
  output logic                   o_busy,
  output logic [7:0]             o_err_count
);
  import sync_arith_pkg::*;

  state_t                 r_state;
  logic                   r_last;
  logic                   r_idx;
  logic signed [BITS-1:0] r_arg_a;
  logic signed [BITS-1:0] r_arg_b;
  logic [1:0]             r_op;
  logic [BITS-1:0]        r_rsp_result;
  logic [3:0]             r_rsp_status;
  logic [1:0]             w_grant;
  logic                   w_idle;
  logic                   w_rsp_take;

  rr_arbiter2 u_rr (
    .i_valid0 (i_req0_valid),
    .i_valid1 (i_req1_valid),
    .i_last   (r_last),
    .o_grant  (w_grant)
  );

  // Ready is masked while reset is asserted so nothing looks accepted.
  assign w_idle       = (r_state == ST_IDLE) & ~i_reset;
  assign o_req0_ready = w_idle & w_grant[0];
  assign o_req1_ready = w_idle & w_grant[1];
  assign w_rsp_take   = r_idx ? i_rsp1_ready : i_rsp0_ready;

  assign o_alu_arg_A  = r_arg_a;
  assign o_alu_arg_B  = r_arg_b;
  assign o_alu_op     = r_op;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_status = r_rsp_status;
  assign o_rsp0_valid = (r_state == ST_RESP) & ~r_idx;
  assign o_rsp1_valid = (r_state == ST_RESP) & r_idx;
  assign o_busy       = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_last       <= 1'b1;
      r_idx        <= 1'b0;
      r_arg_a      <= '0;
      r_arg_b      <= '0;
      r_op         <= 2'b00;
      r_rsp_result <= '0;
      r_rsp_status <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (o_req0_ready | o_req1_ready) begin
            r_arg_a <= o_req1_ready ? i_req1_arg_A : i_req0_arg_A;
            r_arg_b <= o_req1_ready ? i_req1_arg_B : i_req0_arg_B;
            r_op    <= o_req1_ready ? i_req1_op : i_req0_op;
            r_idx   <= o_req1_ready;
            r_last  <= o_req1_ready;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE:   r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_rsp_result <= i_alu_result;
          r_rsp_status <= i_alu_status;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_take) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SYNC_ARITH_ERR_CNT_EN
  logic [7:0] r_err_count;

  // count error responses as they are captured, sticking at 255
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err_count <= 8'd0;
    end else if ((r_state == ST_CAPTURE) && i_alu_status[ERR] && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign o_err_count = r_err_count;
`else
  assign o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_sync_arith_arbiter.sv
// Self-checking bench for sync_arith_arbiter with a registered model of the
// shared arithmetic unit and a transaction-level reference model.
module tb_sync_arith_arbiter;

  logic               clk = 1'b0;
  logic               i_reset;
  logic               i_req0_valid, i_req1_valid;
  logic signed [31:0] i_req0_arg_A, i_req0_arg_B, i_req1_arg_A, i_req1_arg_B;
  logic [1:0]         i_req0_op, i_req1_op;
  logic               o_req0_ready, o_req1_ready;
  logic signed [31:0] o_alu_arg_A, o_alu_arg_B;
  logic [1:0]         o_alu_op;
  logic [31:0]        alu_res;
  logic [3:0]         alu_st;
  logic               o_rsp0_valid, o_rsp1_valid;
  logic               i_rsp0_ready, i_rsp1_ready;
  logic [31:0]        o_rsp_result;
  logic [3:0]         o_rsp_status;
  logic               o_busy;
  logic [7:0]         o_err_count;

  int          total = 0;
  int          bad = 0;
  int          tb_last;
  int          tb_errs;
  logic [31:0] tb_prev_res;
  logic [3:0]  tb_prev_st;
  logic        alu_err = 1'b0;

  always #5 clk = ~clk;

  sync_arith_arbiter #(.BITS(32)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0_valid(i_req0_valid), .i_req1_valid(i_req1_valid),
    .i_req0_arg_A(i_req0_arg_A), .i_req0_arg_B(i_req0_arg_B),
    .i_req1_arg_A(i_req1_arg_A), .i_req1_arg_B(i_req1_arg_B),
    .i_req0_op(i_req0_op), .i_req1_op(i_req1_op),
    .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
    .o_alu_arg_A(o_alu_arg_A), .o_alu_arg_B(o_alu_arg_B), .o_alu_op(o_alu_op),
    .i_alu_result(alu_res), .i_alu_status(alu_st),
    .o_rsp0_valid(o_rsp0_valid), .o_rsp1_valid(o_rsp1_valid),
    .i_rsp0_ready(i_rsp0_ready), .i_rsp1_ready(i_rsp1_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_status(o_rsp_status),
    .o_busy(o_busy), .o_err_count(o_err_count)
  );

  function automatic logic signed [31:0] model_f(input logic signed [31:0] a, input logic signed [31:0] b,
                                                 input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return (a < b) ? 32'sd1 : 32'sd0;
      2'b10:   return b;
      default: return a <<< b[4:0];
    endcase
  endfunction

  function automatic logic [3:0] model_st(input logic err, input logic [31:0] r);
    return {err, 1'b0, (r == 32'd0), 1'b0};
  endfunction

  function automatic int pick(input logic v0, input logic v1, input int last);
    if (v0 && v1) return (last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // shared unit model: registers its inputs every clock
  always @(posedge clk) begin
    alu_res <= model_f(o_alu_arg_A, o_alu_arg_B, o_alu_op);
    alu_st  <= model_st(alu_err, model_f(o_alu_arg_A, o_alu_arg_B, o_alu_op));
  end

  task automatic scramble_reqs();
    i_req0_arg_A = $urandom; i_req0_arg_B = $urandom; i_req0_op = 2'($urandom_range(3, 0));
    i_req1_arg_A = $urandom; i_req1_arg_B = $urandom; i_req1_op = 2'($urandom_range(3, 0));
  endtask

  // One full transaction: handshake, ISSUE, CAPTURE, then RESP held for 'hold' extra cycles.
  task automatic do_txn(input bit skip, input logic v0, input logic v1,
                        input logic signed [31:0] a0, input logic signed [31:0] b0, input logic [1:0] op0,
                        input logic signed [31:0] a1, input logic signed [31:0] b1, input logic [1:0] op1,
                        input int hold);
    int g, exp_cnt;
    logic signed [31:0] ea, eb;
    logic [1:0] eop;
    logic [31:0] er;
    logic [3:0] es;
    if (!skip) begin @(posedge clk); #1; end
    i_req0_valid = v0; i_req1_valid = v1;
    i_req0_arg_A = a0; i_req0_arg_B = b0; i_req0_op = op0;
    i_req1_arg_A = a1; i_req1_arg_B = b1; i_req1_op = op1;
    i_rsp0_ready = 1'b0; i_rsp1_ready = 1'b0;
    g = pick(v0, v1, tb_last);
    @(negedge clk);
    total++; if (o_req0_ready !== (g == 0)) begin bad++; $display("FAIL ready0 got=%b want=%b", o_req0_ready, (g == 0)); end
    total++; if (o_req1_ready !== (g == 1)) begin bad++; $display("FAIL ready1 got=%b want=%b", o_req1_ready, (g == 1)); end
    if (g < 0) begin
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", o_busy); end
      return;
    end
    tb_last = g;
    ea = g ? a1 : a0; eb = g ? b1 : b0; eop = g ? op1 : op0;
    er = model_f(ea, eb, eop); es = model_st(alu_err, er);
    if (alu_err) tb_errs++;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      scramble_reqs();
      @(negedge clk);
      total++; if (o_alu_arg_A !== ea || o_alu_arg_B !== eb || o_alu_op !== eop) begin
        bad++; $display("FAIL alu_drive c=%0d got=%h/%h/%b want=%h/%h/%b", c, o_alu_arg_A, o_alu_arg_B, o_alu_op, ea, eb, eop); end
      total++; if ({o_busy, o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid} !== 5'b10000) begin
        bad++; $display("FAIL mid_flags c=%0d got=%b want=10000", c, {o_busy, o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid}); end
      total++; if (o_rsp_result !== tb_prev_res || o_rsp_status !== tb_prev_st) begin
        bad++; $display("FAIL rsp_hold c=%0d got=%h/%h want=%h/%h", c, o_rsp_result, o_rsp_status, tb_prev_res, tb_prev_st); end
    end
    for (int c = 0; c <= hold; c++) begin
      @(posedge clk); #1;
      if (g == 0) begin i_rsp0_ready = (c == hold); i_rsp1_ready = 1'b1; end
      else begin i_rsp1_ready = (c == hold); i_rsp0_ready = 1'b1; end
      @(negedge clk);
      total++; if (o_rsp0_valid !== (g == 0) || o_rsp1_valid !== (g == 1)) begin
        bad++; $display("FAIL rsp_valid c=%0d got=%b%b want_idx=%0d", c, o_rsp1_valid, o_rsp0_valid, g); end
      total++; if (o_rsp_result !== er || o_rsp_status !== es) begin
        bad++; $display("FAIL rsp_data c=%0d got=%h/%h want=%h/%h", c, o_rsp_result, o_rsp_status, er, es); end
      total++; if ({o_busy, o_req0_ready, o_req1_ready} !== 3'b100) begin
        bad++; $display("FAIL resp_flags c=%0d got=%b want=100", c, {o_busy, o_req0_ready, o_req1_ready}); end
    end
    tb_prev_res = er; tb_prev_st = es;
`ifdef SYNC_ARITH_ERR_CNT_EN
    exp_cnt = (tb_errs > 255) ? 255 : tb_errs;
`else
    exp_cnt = 0;
`endif
    total++; if (o_err_count !== 8'(exp_cnt)) begin bad++; $display("FAIL err_count got=%0d want=%0d", o_err_count, exp_cnt); end
  endtask

  task automatic do_rand(input bit skip, input logic v0, input logic v1, input int hold);
    do_txn(skip, v0, v1, $urandom, $urandom, 2'($urandom_range(3, 0)),
           $urandom, $urandom, 2'($urandom_range(3, 0)), hold);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_rsp0_ready = 1'b0; i_rsp1_ready = 1'b0; scramble_reqs();
    tb_last = 1; tb_errs = 0; tb_prev_res = 32'd0; tb_prev_st = 4'd0;
    #3;
    total++; if ({o_busy, o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid} !== 5'b00000) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {o_busy, o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid}); end
    total++; if (o_alu_arg_A !== 32'sd0 || o_alu_arg_B !== 32'sd0 || o_alu_op !== 2'b00 || o_rsp_result !== 32'd0
                 || o_rsp_status !== 4'd0 || o_err_count !== 8'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%b/%h/%h/%0d want=zeros", o_alu_arg_A, o_alu_arg_B, o_alu_op,
                      o_rsp_result, o_rsp_status, o_err_count); end
    repeat (2) @(posedge clk);
    #1; i_reset = 1'b0;
    do_rand(1'b1, 1'b1, 1'b1, 0);
  endtask

  task automatic test_single();
    do_txn(1'b0, 1'b0, 1'b0, 32'sd0, 32'sd0, 2'b00, 32'sd0, 32'sd0, 2'b00, 0);
    do_txn(1'b0, 1'b1, 1'b0, 32'sd5, 32'sd7, 2'b00, 32'sd1, 32'sd2, 2'b11, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) do_rand(1'b0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    do_rand(1'b0, 1'b1, 1'b1, 5);
    do_rand(1'b0, 1'b1, 1'b1, 0);
    do_rand(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      alu_err = 1'($urandom_range(1, 0));
      do_rand(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)));
    end
    alu_err = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1; i_rsp0_ready = 1'b0; i_rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3; i_reset = 1'b1;
    #1;
    total++; if ({o_busy, o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid} !== 5'b00000) begin
      bad++; $display("FAIL midrst_flags got=%b want=00000", {o_busy, o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid}); end
    total++; if (o_alu_arg_A !== 32'sd0 || o_alu_op !== 2'b00 || o_rsp_result !== 32'd0 || o_err_count !== 8'd0) begin
      bad++; $display("FAIL midrst_data got=%h/%b/%h/%0d want=zeros", o_alu_arg_A, o_alu_op, o_rsp_result, o_err_count); end
    tb_last = 1; tb_errs = 0; tb_prev_res = 32'd0; tb_prev_st = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if ({o_rsp0_valid, o_rsp1_valid, o_busy} !== 3'b000) begin
        bad++; $display("FAIL midrst_hold c=%0d got=%b want=000", c, {o_rsp0_valid, o_rsp1_valid, o_busy}); end
    end
    @(posedge clk); #1; i_reset = 1'b0;
    do_rand(1'b1, 1'b1, 1'b1, 0);
  endtask

  task automatic test_err_count();
    alu_err = 1'b1;
    for (int i = 0; i < 300; i++) do_rand(1'b0, 1'($urandom_range(1, 0)), 1'b1, 0);
    alu_err = 1'b0;
    do_rand(1'b0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    test_err_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
